// File: rtl/boot_pkg.sv
// boot_pkg: shared definitions for the boot loader controller.
//   state_t             - controller state encoding (IDLE, LOAD, HOLD, RUN)
//   HOLD_CYCLES_DEFAULT - default number of cycles the core stays in reset
//                         after the last instruction word is written
package boot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam int HOLD_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/boot_ctrl_if.sv
// boot_ctrl_if: load request, byte stream, instruction-memory write port and
// core status signals of the boot loader.
//   load_start/load_words  - load request and word count (host -> controller)
//   byte_valid/byte_data   - program byte stream (host -> controller)
//   byte_ready             - controller accepts a byte this cycle
//   imem_we/addr/wdata     - instruction-memory write port
//   core_rst_n/busy/done   - core reset and controller status
//   err                    - one-cycle pulse on a rejected load request
// Modports: master = host side, slave = boot controller.
interface boot_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              load_start;
    logic [ADDR_W:0]   load_words;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output load_start, load_words, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
        input  core_rst_n, busy, done, err
    );

    modport slave (
        input  load_start, load_words, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata,
        output core_rst_n, busy, done, err
    );
endinterface

// File: rtl/boot_ctrl_byte_packer.sv
// byte_packer: assembles four accepted bytes into a little-endian 32-bit word.
//   clk, rst   - clock and synchronous active-low reset
//   clear      - restart at byte 0 (new load)
//   accept     - a byte is transferred this cycle
//   byte_data  - the byte being transferred
//   byte_last  - the next accepted byte completes a word
//   word_valid - one-cycle pulse, the cycle after the fourth byte
//   word       - last assembled word, held between pulses
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic        byte_last,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  byte_cnt;
    logic [23:0] partial;

    assign byte_last = (byte_cnt == 2'd3);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt   <= '0;
            partial    <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= '0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_last) begin
                    // Newest byte is the most significant: little-endian order.
                    word       <= {byte_data, partial};
                    word_valid <= 1'b1;
                end else begin
                    partial <= {byte_data, partial[23:8]};
                end
            end
        end
    end
endmodule

// File: rtl/boot_ctrl.sv
// boot_ctrl: loads a program from a byte stream into instruction memory, then
// holds the processor core in reset for HOLD_CYCLES before releasing it.
//   clk, rst - clock and synchronous active-low reset
//   bus      - boot_ctrl_if slave modport (load request, byte stream,
//              instruction-memory write port, core reset and status)
// Parameters: ADDR_W (word-address width), HOLD_CYCLES (post-load reset hold).
module boot_ctrl
    import boot_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    boot_ctrl_if.slave bus
);
    localparam int              HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_next;
    logic [ADDR_W:0]   words_q;
    logic [ADDR_W-1:0] word_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              core_rst_q;
    logic              err_q;

    logic              can_start, len_ok, start_load;
    logic              accept, byte_last, word_end, last_word;
    logic              word_valid;
    logic [31:0]       word;

    // A load may only begin from IDLE or RUN; requests in LOAD/HOLD are dropped.
    assign can_start  = (state == ST_IDLE) || (state == ST_RUN);
    assign len_ok     = (bus.load_words != '0) && (bus.load_words <= MAX_WORDS);
    assign start_load = can_start && bus.load_start && len_ok;
    assign accept     = (state == ST_LOAD) && bus.byte_valid;
    assign word_end   = accept && byte_last;
    assign last_word  = ({1'b0, word_cnt} == (words_q - ONE_WORD));

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_load),
        .accept     (accept),
        .byte_data  (bus.byte_data),
        .byte_last  (byte_last),
        .word_valid (word_valid),
        .word       (word)
    );

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE, ST_RUN: if (start_load)              state_next = ST_LOAD;
            ST_LOAD:         if (word_end && last_word)   state_next = ST_HOLD;
            ST_HOLD:         if (hold_cnt == HOLD_LAST)   state_next = ST_RUN;
            default:                                      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            words_q    <= '0;
            word_cnt   <= '0;
            addr_q     <= '0;
            hold_cnt   <= '0;
            core_rst_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state    <= state_next;
            err_q    <= can_start && bus.load_start && !len_ok;
            hold_cnt <= (state == ST_HOLD) ? hold_cnt + 1'b1 : '0;
            // Registered from the next state so the core reset is glitch-free
            // and high exactly while the controller sits in RUN.
            core_rst_q <= (state_next == ST_RUN);
            if (start_load) begin
                words_q  <= bus.load_words;
                word_cnt <= '0;
            end else if (word_end) begin
                addr_q   <= word_cnt;
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    assign bus.byte_ready = (state == ST_LOAD);
    assign bus.imem_we    = word_valid;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = word;
    assign bus.core_rst_n = core_rst_q;
    assign bus.busy       = (state == ST_LOAD) || (state == ST_HOLD);
    assign bus.done       = (state == ST_RUN);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_boot_ctrl.sv
// tb_boot_ctrl: self-checking bench for boot_ctrl. Expected memory writes are
// queued as bytes are driven and compared by a monitor as writes appear.
module tb_boot_ctrl;
    localparam int AW    = 4;
    localparam int HC    = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    boot_ctrl_if #(.ADDR_W(AW)) bus ();

    boot_ctrl #(.ADDR_W(AW), .HOLD_CYCLES(HC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    logic [7:0] stim[$];

    logic [AW-1:0] fb_addr;
    logic [31:0]   fb_acc;
    int            fb_nb;

    // Write monitor: every imem_we cycle must match the oldest expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst === 1'b1 && bus.imem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%08h", bus.imem_addr, bus.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.imem_addr !== e.addr || bus.imem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write got addr=%0h data=%08h want addr=%0h data=%08h",
                             bus.imem_addr, bus.imem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [AW:0] n);
        bus.load_start = 1'b1;
        bus.load_words = n;
        fb_addr = '0;
        fb_acc  = '0;
        fb_nb   = 0;
        step();
        bus.load_start = 1'b0;
    endtask

    // Drive every queued byte, with 'gap' idle cycles after each one.
    task automatic feed_bytes(input int gap);
        logic [7:0] b;
        while (stim.size() > 0) begin
            b = stim.pop_front();
            checks++;
            if (bus.byte_ready !== 1'b1) begin
                errors++;
                $display("FAIL byte_ready_before_byte got=%b want=1", bus.byte_ready);
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = b;
            fb_acc = {b, fb_acc[31:8]};
            fb_nb++;
            if (fb_nb % 4 == 0) begin
                exp_q.push_back('{addr: fb_addr, data: fb_acc});
                fb_addr = fb_addr + 1'b1;
            end
            step();
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'($urandom);
            for (int g = 0; g < gap; g++) begin
                if (stim.size() > 0) begin
                    checks++;
                    if (bus.byte_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL byte_ready_in_gap got=%b want=1", bus.byte_ready);
                    end
                end
                step();
            end
        end
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
    endtask

    task automatic push_basic_program();
        stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    endtask

    task automatic wait_run(input int budget);
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (bus.done !== 1'b1 || bus.core_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL wait_run done=%b core_rst_n=%b want 1/1 within %0d cycles",
                     bus.done, bus.core_rst_n, budget);
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending_writes got=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [AW+37:0] got;
        got = {bus.byte_ready, bus.imem_we, bus.busy, bus.done, bus.err,
               bus.core_rst_n, bus.imem_addr, bus.imem_wdata};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s outputs got=%h want=0", name, got);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) step();
        check_reset_outputs("reset_state");
        rst = 1'b1;
        step();
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_bad_len();
        logic [AW:0] bad [2];
        bad[0] = '0;
        bad[1] = (AW+1)'(DEPTH + 1);
        for (int i = 0; i < 2; i++) begin
            start_load(bad[i]);
            checks++;
            if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL bad_len_%0d err=%b busy=%b ready=%b want 1/0/0",
                         i, bus.err, bus.busy, bus.byte_ready);
            end
            step();
            checks++;
            if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL bad_len_after_%0d err=%b busy=%b done=%b want 0/0/0",
                         i, bus.err, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_basic();
        start_load((AW+1)'(2));
        checks++;
        if (bus.busy !== 1'b1 || bus.core_rst_n !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL basic_enter_load busy=%b core_rst_n=%b err=%b want 1/0/0",
                     bus.busy, bus.core_rst_n, bus.err);
        end
        push_basic_program();
        feed_bytes(0);
        checks++;
        if (bus.byte_ready !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_enter_hold ready=%b busy=%b done=%b want 0/1/0",
                     bus.byte_ready, bus.busy, bus.done);
        end
        for (int i = 1; i <= HC; i++) begin
            step();
            checks++;
            if (bus.core_rst_n !== (i == HC) || bus.done !== (i == HC)) begin
                errors++;
                $display("FAIL basic_hold_cycle_%0d core_rst_n=%b done=%b want %b",
                         i, bus.core_rst_n, bus.done, (i == HC));
            end
        end
        check_queue_empty("basic");
    endtask

    task automatic test_toggle();
        start_load((AW+1)'(2));
        push_basic_program();
        feed_bytes(1);
        wait_run(HC + 4);
        check_queue_empty("toggle");
    endtask

    task automatic test_reload_from_run();
        start_load((AW+1)'(1));
        checks++;
        if (bus.core_rst_n !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reload core_rst_n=%b done=%b busy=%b want 0/0/1",
                     bus.core_rst_n, bus.done, bus.busy);
        end
        push_random(4);
        feed_bytes(0);
        wait_run(HC + 4);
        check_queue_empty("reload");
    endtask

    task automatic test_ignore_start();
        start_load((AW+1)'(2));
        push_random(2);
        feed_bytes(0);
        bus.load_start = 1'b1;
        bus.load_words = (AW+1)'(3);
        step();
        bus.load_start = 1'b0;
        checks++;
        if (bus.err !== 1'b0 || bus.byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start err=%b ready=%b want 0/1", bus.err, bus.byte_ready);
        end
        push_random(6);
        feed_bytes(0);
        checks++;
        if (bus.byte_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start_count ready=%b busy=%b want 0/1 after 8 bytes",
                     bus.byte_ready, bus.busy);
        end
        wait_run(HC + 4);
        check_queue_empty("ignore_start");
    endtask

    task automatic test_full_depth();
        start_load((AW+1)'(DEPTH));
        push_random(4 * DEPTH);
        feed_bytes(0);
        wait_run(HC + 4);
        check_queue_empty("full_depth");
    endtask

    task automatic test_reset_mid_load();
        start_load((AW+1)'(3));
        push_random(6);
        feed_bytes(0);
        rst = 1'b0;
        step();
        check_reset_outputs("mid_load_reset");
        rst = 1'b1;
        repeat (4) step();
        check_reset_outputs("after_mid_load_reset");
        check_queue_empty("mid_load");
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.load_words = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        test_reset();
        test_bad_len();
        test_basic();
        test_toggle();
        test_reload_from_run();
        test_ignore_start();
        test_full_depth();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/boot_ctrl.md
BOOT_CTRL -- requirements
Module: boot_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width (depth 2**ADDR_W words).
REQ-002 Parameter HOLD_CYCLES, default 4, cycles core reset stays asserted after the last word is written.
REQ-003 CLK  input  1  single clock; all logic on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-low.
REQ-005 load_start  input  1  one-cycle request to begin a program load.
REQ-006 load_words  input  ADDR_W+1  number of 32-bit words to load, sampled with load_start.
REQ-007 byte_valid  input  1  byte source has data.
REQ-008 byte_data  input  8  program byte.
REQ-009 byte_ready  output  1  controller accepts a byte this cycle.
REQ-010 imem_we  output  1  instruction-memory write strobe.
REQ-011 imem_addr  output  ADDR_W  word address of the write.
REQ-012 imem_wdata  output  32  word written.
REQ-013 core_rst_n  output  1  active-low reset to the processor core (drives core RST).
REQ-014 busy  output  1  high in LOAD and HOLD.
REQ-015 done  output  1  high in RUN.
REQ-016 err  output  1  one-cycle pulse on a rejected load_start.

Function
REQ-017 States IDLE, LOAD, HOLD, RUN; byte transfer occurs only when byte_valid and byte_ready are both high.
REQ-018 IDLE: byte_ready=0, core_rst_n=0; load_start with 1 <= load_words <= 2**ADDR_W -> LOAD, word counter and byte counter cleared.
REQ-019 load_start with load_words==0 or >2**ADDR_W: err pulses the next cycle, state unchanged.
REQ-020 LOAD: byte_ready=1 every cycle, no stall; bytes packed little-endian (first byte -> bits 7:0, fourth -> bits 31:24).
REQ-021 On acceptance of the fourth byte of a word, imem_we=1 for exactly the next cycle with imem_addr = word index (0-based) and imem_wdata = assembled word.
REQ-022 After acceptance of the last byte of word load_words-1, the next cycle is HOLD; byte_ready=0 from that cycle.
REQ-023 HOLD: core_rst_n=0 for exactly HOLD_CYCLES cycles, then RUN.
REQ-024 RUN: core_rst_n=1, done=1, byte_ready=0; a valid load_start returns to LOAD and drives core_rst_n=0 in the next cycle.
REQ-025 load_start in LOAD or HOLD is ignored with no err.
REQ-026 byte_valid with byte_ready=0 is ignored; no byte is consumed.
REQ-027 imem_we is 0 outside the single write cycle; imem_addr/imem_wdata hold their last values.
REQ-028 core_rst_n is registered, glitch-free, never 1 outside RUN.

Reset
REQ-029 RST=0 at a rising edge forces IDLE; core_rst_n=0, byte_ready=0, imem_we=0, busy=0, done=0, err=0, imem_addr=0, imem_wdata=0, counters 0.
REQ-030 Reset mid-LOAD discards the partial word; no write is issued for it.

Structure
REQ-031 Package boot_pkg holds the state encoding and the default HOLD_CYCLES constant.
REQ-032 One sub-module byte_packer (byte counter, 4-byte shift assembly, word-complete pulse); the FSM, word counter and hold counter stay in boot_ctrl.

Verification
REQ-033 load_words=2, bytes 13,00,00,00,93,00,10,00 every cycle -> writes addr0=00000013 then addr1=00100093; core_rst_n rises exactly 4 cycles after entering HOLD.
REQ-034 Same load with byte_valid toggling every other cycle -> identical writes; byte_ready stays 1 until last byte.
REQ-035 load_words=0 and load_words=2**ADDR_W+1 -> err one cycle, no write, state IDLE.
REQ-036 RST=0 after 6 bytes of a 3-word load -> only addr0 written; all outputs at reset values next cycle.
REQ-037 In RUN, load_start with load_words=1 -> core_rst_n=0 next cycle, done=0, new word written at addr0.
REQ-038 load_start during LOAD -> ignored, original load completes with correct count.
